// File: rtl/bp_me_cache_dma_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_me_cache_dma_responder_pkg                                            |
// | Shared types for the cache DMA responder: the responder state encoding   |
// | and the DMA packet layout {write_not_read, addr}.                        |
// | Ports: none (package only).                                              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+

`ifndef BP_ME_CACHE_DMA_RESPONDER_PKG_MACROS
`define BP_ME_CACHE_DMA_RESPONDER_PKG_MACROS

// Width of a DMA packet for a given byte-address width.
`define BP_CACHE_DMA_PKT_WIDTH(addr_width_mp) (1 + (addr_width_mp))

// Declares the DMA packet struct for a given byte-address width; the
// write_not_read flag sits in the MSB.
`define BP_CACHE_DMA_PKT_S(addr_width_mp) \
  typedef struct packed { \
    logic                         write_not_read; \
    logic [(addr_width_mp)-1:0]   addr; \
  } bp_cache_dma_pkt_s

`endif

package bp_me_cache_dma_responder_pkg;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_delay = 2'd1,
    e_read  = 2'd2,
    e_write = 2'd3
  } bp_me_dma_resp_state_e;

endpackage

`default_nettype wire

// File: rtl/bp_me_cache_dma_responder_two_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_me_cache_dma_responder_two_fifo                                       |
// | Two-entry valid/ready FIFO buffering fill beats read from the backing    |
// | store before they are handed to the cache.                               |
// | Ports: clk, rst (sync, active-high); i_data/i_v/o_ready enqueue side;    |
// |        o_data/o_v/i_yumi dequeue side (i_yumi only while o_v is high).   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bp_me_cache_dma_responder_two_fifo
  import bp_me_cache_dma_responder_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_v,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_v,
  input  logic             i_yumi
);

  logic [WIDTH-1:0] slot_q [2];
  logic             rptr_q, rptr_d;
  logic             wptr_q, wptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             w_enq, w_deq;

  assign o_ready = (cnt_q != 2'd2);
  assign o_v     = (cnt_q != 2'd0);
  assign o_data  = slot_q[rptr_q];

  assign w_enq = i_v & o_ready;
  assign w_deq = i_yumi & o_v;

  always_comb begin
    rptr_d = rptr_q ^ w_deq;
    wptr_d = wptr_q ^ w_enq;
    cnt_d  = cnt_q + {1'b0, w_enq} - {1'b0, w_deq};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      slot_q[wptr_q] <= i_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_me_cache_dma_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_me_cache_dma_responder                                                |
// | Memory-side endpoint for one L2 bank's cache DMA port. Accepts a packet, |
// | waits latency_p cycles, then either absorbs a block of write beats into  |
// | the backing store or streams a block of fill beats back to the cache.   |
// | Ports: clk_i, reset_i (sync, active-high)                                |
// |        dma_pkt_i/_v_i/_ready_and_o         packet in {wnr, addr}        |
// |        dma_data_o/_v_o, dma_data_ready_and_i   fill beats out           |
// |        dma_data_i/_v_i, dma_data_ready_and_o   write beats in           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bp_me_cache_dma_responder
  import bp_me_cache_dma_responder_pkg::*;
#(
  parameter int daddr_width_p = 28,
  parameter int fill_width_p  = 64,
  parameter int block_width_p = 512,
  parameter int mem_els_p     = 4096,
  parameter int latency_p     = 4
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,

  input  logic [`BP_CACHE_DMA_PKT_WIDTH(daddr_width_p)-1:0] dma_pkt_i,
  input  logic                                      dma_pkt_v_i,
  output logic                                      dma_pkt_ready_and_o,

  output logic [fill_width_p-1:0]                   dma_data_o,
  output logic                                      dma_data_v_o,
  input  logic                                      dma_data_ready_and_i,

  input  logic [fill_width_p-1:0]                   dma_data_i,
  input  logic                                      dma_data_v_i,
  output logic                                      dma_data_ready_and_o
);

  localparam int c_beats    = block_width_p / fill_width_p;
  localparam int c_beat_w   = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam int c_byte_off = $clog2(fill_width_p / 8);
  localparam int c_mem_aw   = $clog2(mem_els_p);
  localparam int c_lat_w    = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  localparam logic [c_beat_w-1:0] c_last_beat  = c_beat_w'(c_beats - 1);
  // Clears the beat-within-block bits so every burst starts block-aligned.
  localparam logic [c_mem_aw-1:0] c_align_mask = ~(c_mem_aw'(c_beats - 1));

  `BP_CACHE_DMA_PKT_S(daddr_width_p);

  bp_cache_dma_pkt_s w_pkt;
  logic [daddr_width_p-1:0] w_beat_idx;
  logic [c_mem_aw-1:0]      w_pkt_base;

  assign w_pkt      = dma_pkt_i;
  assign w_beat_idx = w_pkt.addr >> c_byte_off;
  // Taking only the low index bits is the modulo-depth wrap of the store.
  assign w_pkt_base = w_beat_idx[c_mem_aw-1:0] & c_align_mask;

  bp_me_dma_resp_state_e state_q, state_d;
  logic                  wnr_q, wnr_d;
  logic [c_mem_aw-1:0]   base_q, base_d;
  logic [c_beat_w-1:0]   beat_q, beat_d;
  logic [c_lat_w-1:0]    delay_q, delay_d;
  logic [1:0]            used_q, used_d;     // FIFO occupancy + reads in flight
  logic                  inflight_q, inflight_d;

  logic                    w_mem_v, w_mem_w;
  logic [c_mem_aw-1:0]     w_mem_addr;
  logic [fill_width_p-1:0] mem_rdata_q;
  logic [fill_width_p-1:0] mem_q [mem_els_p];

  logic w_fifo_v, w_fifo_ready, w_deq, w_issue, w_credit_ok;
  logic w_unused;

  assign w_mem_addr = base_q + c_mem_aw'(beat_q);

  // A beat leaving the FIFO this cycle frees a slot for a read issued this
  // same cycle; counting it keeps the read stream at one beat per cycle.
  assign w_deq       = w_fifo_v & dma_data_ready_and_i & ~reset_i;
  assign w_credit_ok = (used_q != 2'd2) | w_deq;
  assign w_issue     = w_mem_v & ~w_mem_w;

  always_comb begin
    state_d              = state_q;
    wnr_d                = wnr_q;
    base_d               = base_q;
    beat_d               = beat_q;
    delay_d              = delay_q;
    dma_pkt_ready_and_o  = 1'b0;
    dma_data_ready_and_o = 1'b0;
    w_mem_v              = 1'b0;
    w_mem_w              = 1'b0;

    // Nothing handshakes while reset is held, so readies stay low then.
    if (!reset_i) begin
      unique case (state_q)
        e_ready: begin
          dma_pkt_ready_and_o = 1'b1;
          if (dma_pkt_v_i) begin
            wnr_d   = w_pkt.write_not_read;
            base_d  = w_pkt_base;
            beat_d  = '0;
            delay_d = c_lat_w'(latency_p);
            if (latency_p == 0) begin
              state_d = w_pkt.write_not_read ? e_write : e_read;
            end else begin
              state_d = e_delay;
            end
          end
        end

        e_delay: begin
          delay_d = delay_q - c_lat_w'(1);
          if (delay_q == c_lat_w'(1)) begin
            state_d = wnr_q ? e_write : e_read;
          end
        end

        e_write: begin
          dma_data_ready_and_o = 1'b1;
          if (dma_data_v_i) begin
            w_mem_v = 1'b1;
            w_mem_w = 1'b1;
            beat_d  = beat_q + c_beat_w'(1);
            if (beat_q == c_last_beat) begin
              state_d = e_ready;
            end
          end
        end

        e_read: begin
          if (w_credit_ok) begin
            w_mem_v = 1'b1;
            beat_d  = beat_q + c_beat_w'(1);
            // The FIFO keeps draining after we leave; only issue stops here.
            if (beat_q == c_last_beat) begin
              state_d = e_ready;
            end
          end
        end

        default: state_d = e_ready;
      endcase
    end
  end

  always_comb begin
    used_d     = used_q + {1'b0, w_issue} - {1'b0, w_deq};
    inflight_d = w_issue;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_ready;
      wnr_q      <= 1'b0;
      base_q     <= '0;
      beat_q     <= '0;
      delay_q    <= '0;
      used_q     <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wnr_q      <= wnr_d;
      base_q     <= base_d;
      beat_q     <= beat_d;
      delay_q    <= delay_d;
      used_q     <= used_d;
      inflight_q <= inflight_d;
    end
  end

  // Single-port synchronous backing store; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_v & w_mem_w) begin
      mem_q[w_mem_addr] <= dma_data_i;
    end
    if (w_mem_v & ~w_mem_w) begin
      mem_rdata_q <= mem_q[w_mem_addr];
    end
  end

  // The credit count guarantees the FIFO has room whenever read data lands,
  // so its ready output is never consulted.
  bp_me_cache_dma_responder_two_fifo #(
    .WIDTH (fill_width_p)
  ) u_fill_fifo (
    .clk     (clk_i),
    .rst     (reset_i),
    .i_data  (mem_rdata_q),
    .i_v     (inflight_q),
    .o_ready (w_fifo_ready),
    .o_data  (dma_data_o),
    .o_v     (w_fifo_v),
    .i_yumi  (w_deq)
  );

  assign dma_data_v_o = w_fifo_v & ~reset_i;

  assign w_unused = ^{w_beat_idx[daddr_width_p-1:c_mem_aw], w_fifo_ready};

endmodule

`default_nettype wire

// File: tb/tb_bp_me_cache_dma_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bp_me_cache_dma_responder                                             |
// | Self-checking bench: two responders (latency 4 and latency 0) driven by  |
// | directed and random bursts, checked against a flat array memory model.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bp_me_cache_dma_responder;

  localparam int AW    = 28;
  localparam int FW    = 64;
  localparam int BEATS = 8;
  localparam int ELS   = 4096;
  localparam int LIM   = 300;

  logic clk;
  logic rst;

  logic [AW:0]   pkt      [2];
  logic          pkt_v    [2];
  wire           pkt_rdy  [2];
  wire  [FW-1:0] dout     [2];
  wire           dout_v   [2];
  logic          dout_rdy [2];
  logic [FW-1:0] din      [2];
  logic          din_v    [2];
  wire           din_rdy  [2];

  logic [FW-1:0] model [2][ELS];

  int n_cmp;
  int n_bad;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bp_me_cache_dma_responder #(
      .daddr_width_p (AW),
      .fill_width_p  (FW),
      .block_width_p (FW * BEATS),
      .mem_els_p     (ELS),
      .latency_p     ((g == 0) ? 4 : 0)
    ) u_dut (
      .clk_i                (clk),
      .reset_i              (rst),
      .dma_pkt_i            (pkt[g]),
      .dma_pkt_v_i          (pkt_v[g]),
      .dma_pkt_ready_and_o  (pkt_rdy[g]),
      .dma_data_o           (dout[g]),
      .dma_data_v_o         (dout_v[g]),
      .dma_data_ready_and_i (dout_rdy[g]),
      .dma_data_i           (din[g]),
      .dma_data_v_i         (din_v[g]),
      .dma_data_ready_and_o (din_rdy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int s);
    return (s == 0) ? 4 : 0;
  endfunction

  // Block-aligned beat index, wrapped to the store depth.
  function automatic int blk_of(input logic [AW-1:0] addr);
    int b;
    b = int'(addr) / (FW / 8);
    b = (b / BEATS) * BEATS;
    return b % ELS;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a packet and returns once it has been accepted.
  task automatic send_pkt(input int s, input logic wnr, input logic [AW-1:0] addr);
    int cyc;
    pkt[s]   = {wnr, addr};
    pkt_v[s] = 1'b1;
    cyc      = 0;
    while (!pkt_rdy[s] && cyc < LIM) begin
      step();
      cyc++;
    end
    chk("pkt_accept_bound", 64'(cyc < LIM), 64'd1);
    step();
    pkt_v[s] = 1'b0;
  endtask

  // mode 0: beats 1..8, else random data; valid is randomly gapped.
  task automatic do_write(input int s, input logic [AW-1:0] addr, input int mode);
    int cyc, i, blk;
    logic [FW-1:0] d;
    logic xfer;
    blk = blk_of(addr);
    // Valid is held high through the delay so a premature accept shows up.
    din[s]   = (mode == 0) ? FW'(1) : {$urandom, $urandom};
    din_v[s] = 1'b1;
    send_pkt(s, 1'b1, addr);
    cyc = 0;
    while (!din_rdy[s] && cyc < LIM) begin
      step();
      cyc++;
    end
    chk("wr_ready_delay", 64'(cyc), 64'(lat_of(s)));
    i   = 0;
    cyc = 0;
    while (i < BEATS && cyc < LIM) begin
      d        = (mode == 0) ? FW'(i + 1) : {$urandom, $urandom};
      din[s]   = d;
      din_v[s] = ($urandom_range(0, 3) != 0);
      xfer     = din_v[s] & din_rdy[s];
      step();
      cyc++;
      if (xfer) begin
        model[s][(blk + i) % ELS] = d;
        i++;
      end
    end
    din_v[s] = 1'b0;
    chk("wr_beats", 64'(i), 64'(BEATS));
    chk("wr_end_din_rdy", 64'(din_rdy[s]), 64'd0);
    chk("wr_end_pkt_rdy", 64'(pkt_rdy[s]), 64'd1);
  endtask

  // rmode 0: ready held 1; 1: ready 1,0,0 repeating; 2: random ready.
  task automatic do_read(input int s, input logic [AW-1:0] addr, input int rmode);
    int cyc, k, blk, first, last;
    logic r, hold;
    logic [FW-1:0] held;
    blk = blk_of(addr);
    send_pkt(s, 1'b0, addr);
    k = 0; cyc = 0; hold = 1'b0; held = '0; first = 0; last = 0;
    while (k < BEATS && cyc < LIM) begin
      r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      dout_rdy[s] = r;
      if (hold) begin
        chk("rd_hold_v", 64'(dout_v[s]), 64'd1);
        chk("rd_hold_data", dout[s], held);
      end
      hold = dout_v[s] & ~r;
      held = dout[s];
      if (dout_v[s] && r) begin
        chk("rd_data", dout[s], model[s][(blk + k) % ELS]);
        if (k == 0) first = cyc;
        last = cyc;
        k++;
      end
      step();
      cyc++;
    end
    chk("rd_beats", 64'(k), 64'(BEATS));
    if (rmode == 0) chk("rd_consecutive", 64'(last - first), 64'(BEATS - 1));
    dout_rdy[s] = 1'b1;
    step();
    step();
    chk("rd_no_extra", 64'(dout_v[s]), 64'd0);
    dout_rdy[s] = 1'b0;
  endtask

  // Two read packets held valid back to back with the cache always ready.
  task automatic back_to_back(input int s, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    logic [AW-1:0] a [2];
    logic [FW-1:0] expq [2*BEATS];
    int acc [2];
    int np, k, cyc;
    a[0] = a0;
    a[1] = a1;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < BEATS; i++)
        expq[j*BEATS + i] = model[s][(blk_of(a[j]) + i) % ELS];
    np = 0; k = 0; cyc = 0; acc[0] = 0; acc[1] = 0;
    pkt[s]      = {1'b0, a[0]};
    pkt_v[s]    = 1'b1;
    dout_rdy[s] = 1'b1;
    while (k < 2*BEATS && cyc < LIM) begin
      if (np < 2 && pkt_v[s] && pkt_rdy[s]) begin
        acc[np] = cyc;
        np++;
      end
      if (dout_v[s]) begin
        chk("b2b_data", dout[s], expq[k]);
        k++;
      end
      step();
      cyc++;
      pkt_v[s] = (np < 2);
      if (np < 2) pkt[s] = {1'b0, a[np]};
    end
    pkt_v[s]    = 1'b0;
    dout_rdy[s] = 1'b0;
    chk("b2b_beats", 64'(k), 64'(2*BEATS));
    chk("b2b_accepts", 64'(np), 64'd2);
    // latency cycles, then one cycle per beat issued, then back in ready
    chk("b2b_accept_gap", 64'(acc[1] - acc[0]), 64'(lat_of(s) + BEATS + 1));
  endtask

  task automatic reset_mid_read(input int s, input logic [AW-1:0] addr);
    int k, cyc, blk;
    blk = blk_of(addr);
    send_pkt(s, 1'b0, addr);
    dout_rdy[s] = 1'b1;
    k = 0; cyc = 0;
    while (k < 3 && cyc < LIM) begin
      if (dout_v[s]) begin
        chk("midrst_pre_data", dout[s], model[s][(blk + k) % ELS]);
        k++;
      end
      step();
      cyc++;
    end
    chk("midrst_pre_beats", 64'(k), 64'd3);
    rst = 1'b1;
    step();
    chk("midrst_dout_v", 64'(dout_v[s]), 64'd0);
    chk("midrst_pkt_rdy", 64'(pkt_rdy[s]), 64'd0);
    chk("midrst_din_rdy", 64'(din_rdy[s]), 64'd0);
    rst = 1'b0;
    step();
    chk("postrst_pkt_rdy", 64'(pkt_rdy[s]), 64'd1);
    chk("postrst_dout_v", 64'(dout_v[s]), 64'd0);
    step();
    step();
    chk("postrst_no_stale", 64'(dout_v[s]), 64'd0);
    dout_rdy[s] = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] ra, rb;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int s = 0; s < 2; s++) begin
      pkt[s] = '0; pkt_v[s] = 1'b0; dout_rdy[s] = 1'b0;
      din[s] = '0; din_v[s] = 1'b0;
    end
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      chk("rst_pkt_rdy", 64'(pkt_rdy[s]), 64'd0);
      chk("rst_dout_v", 64'(dout_v[s]), 64'd0);
      chk("rst_din_rdy", 64'(din_rdy[s]), 64'd0);
    end
    rst = 1'b0;
    step();
    for (int s = 0; s < 2; s++) chk("first_pkt_rdy", 64'(pkt_rdy[s]), 64'd1);

    // Directed block at 0x1040, read aligned and unaligned, two ready styles.
    do_write(0, 28'h000_1040, 0);
    do_read(0, 28'h000_1040, 0);
    do_read(0, 28'h000_1058, 1);

    // Aliasing across the store depth: block index 4088.
    do_write(0, 28'(4088*8 + ELS*8*1), 1);
    do_read(0, 28'(4088*8), 0);
    do_read(0, 28'(4088*8 + ELS*8*3), 2);

    // Random blocks with random valid/ready patterns.
    repeat (4) begin
      ra = 28'($urandom_range(0, (1 << AW) - 1));
      do_write(0, ra, 1);
      do_read(0, ra, 2);
    end

    // Zero-latency responder: two blocks, then back-to-back reads.
    ra = 28'($urandom_range(0, (1 << AW) - 1));
    rb = 28'($urandom_range(0, (1 << AW) - 1));
    do_write(1, ra, 1);
    do_write(1, rb, 1);
    back_to_back(1, ra, rb);
    do_read(1, rb, 1);

    // Reset in the middle of a read burst, then a clean read of 0x1040.
    reset_mid_read(0, 28'(4088*8));
    do_read(0, 28'h000_1040, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bp_me_cache_dma_responder.md
Name: bp_me_cache_dma_responder

Overview:
- Memory-side responder for one L2 bank's cache DMA interface.
- Accepts DMA packets and block write data from a bsg_cache-style L2 slice.
- Returns block fill data from an internal synchronous single-port memory, after a programmable latency.
- Used as the DRAM endpoint in simulation/FPGA builds of the unicore; instantiate once per L2 bank.

Parameters:
- daddr_width_p, 28, DMA byte address width.
- fill_width_p, 64, data beat width in bits.
- block_width_p, 512, cache block width in bits; beats_lp = block_width_p/fill_width_p.
- mem_els_p, 4096, backing-store depth in beats; power of two.
- latency_p, 4, idle cycles between packet accept and first beat transfer; 0 is legal.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- dma_pkt_i  in  daddr_width_p+1  {write_not_read, addr}; MSB is write_not_read.
- dma_pkt_v_i  in  1  packet valid.
- dma_pkt_ready_and_o  out  1  packet ready (ready-and).
- dma_data_o  out  fill_width_p  read fill beat to cache.
- dma_data_v_o  out  1  fill beat valid.
- dma_data_ready_and_i  in  1  cache accepts fill beat.
- dma_data_i  in  fill_width_p  evict/write beat from cache.
- dma_data_v_i  in  1  write beat valid.
- dma_data_ready_and_o  out  1  responder accepts write beat.

Behaviour:
- Clocking and handshakes:
  - One clock domain.
  - All handshakes are valid/ready-and: a transfer occurs on a cycle where v & ready are both high.
- State machine, states e_ready, e_delay, e_read, e_write:
  - e_ready: dma_pkt_ready_and_o=1, no other input accepted. On a packet transfer, latch wnr and the base beat index, clear the beat counter, and load the delay counter with latency_p.
    - latency_p=0: go to e_read or e_write.
    - otherwise: go to e_delay.
  - e_delay: decrement the counter each cycle. When it reaches 1, go to e_read or e_write, so exactly latency_p cycles are spent in e_delay.
  - e_write: dma_data_ready_and_o=1. Each transfer writes dma_data_i to mem[base+beat] in the same cycle and increments beat. On the transfer of beat beats_lp-1, go to e_ready.
  - e_read: issue one memory read per cycle when credit is available, and increment beat. After issuing beat beats_lp-1, go to e_ready; the output FIFO keeps draining.
- Address mapping:
  - Beat index = (addr >> log2(fill_width_p/8)) with the low log2(beats_lp) bits forced to 0, so the address is block-aligned.
  - Memory index = (base + beat) mod mem_els_p; it wraps silently.
- Read path:
  - The memory has 1-cycle read latency. Read data enters a 2-entry FIFO that drives dma_data_o/v_o.
  - A read may issue only when (FIFO occupancy + reads in flight) < 2. This gives full throughput of 1 beat/cycle when dma_data_ready_and_i=1 and never overflows.
  - Beats are returned in index order.
- Write/read ordering:
  - The single memory port is used by reads only in e_read and by writes only in e_write, so there is no port conflict.
  - A read packet following a write to the same block returns the new data.
- Reset:
  - reset_i forces e_ready, clears all counters, FIFO and in-flight flags.
  - Output reset values: dma_pkt_ready_and_o=0 during reset and 1 on the first cycle after; dma_data_v_o=0; dma_data_ready_and_o=0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst. Partially written beats remain; pending fill beats are dropped.
- Boundary behaviour:
  - Packets presented outside e_ready are held off, not dropped.
  - Write beats presented outside e_write are held off.
  - dma_data_v_o may remain high across a transition into e_ready and into acceptance of the next packet.

Decomposition:
- Shared package (bp_me_pkg):
  - state enum bp_me_dma_resp_state_e.
  - packed struct bp_cache_dma_pkt_s {write_not_read, addr} with width macro.
- Storage: bsg_mem_1rw_sync (mem_els_p × fill_width_p).
- One natural sub-module: bsg_two_fifo for the read return buffer. The credit counter stays in the top module.

Test Plan:
- Write then read, latency_p=4, addr 0x0000_1040, write beats 0x1..0x8 → dma_data_ready_and_o rises 4 cycles after packet accept; a read packet to 0x0000_1040 returns 0x1..0x8 in order.
- Unaligned read addr 0x0000_1058 → returns the same block as 0x0000_1040.
- Read with dma_data_ready_and_i toggling 1,0,0,1… → no beat lost or duplicated, dma_data_o stable while v=1 and not ready; with ready held at 1, beats arrive on 8 consecutive cycles.
- latency_p=0, back-to-back read packets held valid → second packet accepted only after the first's last read issue; 16 beats total, correct order.
- Address wrap, mem_els_p=4096, block at beat index 4088 via addr (4088*8)+4096*8*k → written data aliases to block index 4088; read back from either alias matches.
- reset_i asserted during beat 3 of an 8-beat read → dma_data_v_o=0 next cycle; ready=1 for a packet after reset; next read of a previously written block returns correct data.
